// File: rtl/eth_rx_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_frame_writer
// Brief    : Packs an 8-bit Avalon-ST RX stream into 32-bit words and writes
//            each frame into a ring of RAM slots, closing it with a header.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_frame_writer #(
  parameter int BASE_WORD  = 0,
  parameter int SLOT_WORDS = 384,
  parameter int NUM_SLOTS  = 8,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        st_data,
  input  logic              st_valid,
  input  logic              st_sop,
  input  logic              st_eop,
  input  logic              st_error,
  output logic              st_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  input  logic              slot_release,
  output logic [3:0]        frames_pending,
  output logic [3:0]        wr_slot,
  output logic [15:0]       drop_count,
  output logic              irq
);

  localparam logic [2:0]  c_idle      = 3'd0;
  localparam logic [2:0]  c_data      = 3'd1;
  localparam logic [2:0]  c_flush     = 3'd2;
  localparam logic [2:0]  c_hdr       = 3'd3;
  localparam logic [2:0]  c_drop      = 3'd4;
  localparam logic [10:0] c_max_bytes = 11'd1532;

  logic [2:0]        r_state, w_state_nxt;
  logic              r_ready;
  logic [10:0]       r_count, w_count_nxt;
  logic [31:0]       r_word, w_word_nxt;
  logic              r_err, w_err_nxt;
  logic [3:0]        r_wr_slot, r_pending;
  logic [15:0]       r_drop;
  logic              r_wr, w_wr_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [3:0]        r_be, w_be_nxt;
  logic [31:0]       r_data, w_data_nxt;
  logic              w_drop_inc, w_store;

  logic              w_accept, w_full, w_commit, w_release;
  logic [10:0]       w_cur_count;
  logic [1:0]        w_lane;
  logic [3:0]        w_lane_be;
  logic [31:0]       w_packed;
  logic [ADDR_W-1:0] w_slot_base;

  assign w_accept    = st_valid & r_ready;
  assign w_full      = (r_pending == 4'(NUM_SLOTS));
  assign w_commit    = (r_state == c_hdr);
  assign w_release   = slot_release & (r_pending != 4'd0);
  assign w_slot_base = ADDR_W'(BASE_WORD) + ADDR_W'(r_wr_slot) * ADDR_W'(SLOT_WORDS);

  // A sop (or any first byte) always restarts packing at lane 0.
  assign w_cur_count = (r_state == c_data && !st_sop) ? r_count : 11'd0;
  assign w_lane      = w_cur_count[1:0];
  assign w_lane_be   = {w_lane == 2'd3, w_lane >= 2'd2, w_lane != 2'd0, 1'b1};

  always_comb begin
    w_packed = (w_lane == 2'd0) ? 32'd0 : r_word;
    w_packed[{w_lane, 3'b000} +: 8] = st_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_word_nxt  = r_word;
    w_err_nxt   = r_err;
    w_drop_inc  = 1'b0;
    w_store     = 1'b0;
    w_wr_nxt    = 1'b0;
    w_addr_nxt  = '0;
    w_be_nxt    = 4'd0;
    w_data_nxt  = 32'd0;
    case (r_state)
      c_idle, c_drop: begin
        if (w_accept && st_sop) begin
          if (w_full) begin
            w_drop_inc  = 1'b1;
            w_state_nxt = st_eop ? c_idle : c_drop;
          end else begin
            w_store = 1'b1;
          end
        end else if (w_accept && st_eop) begin
          w_state_nxt = c_idle;
        end
      end
      c_data: begin
        if (w_accept) begin
          if (st_sop) begin
            w_drop_inc = 1'b1;
            w_store    = 1'b1;
          end else if (r_count == c_max_bytes) begin
            w_drop_inc  = 1'b1;
            w_state_nxt = st_eop ? c_idle : c_drop;
          end else begin
            w_store = 1'b1;
          end
        end
      end
      c_flush: begin
        // Trailing data already went out with the eop beat; this cycle queues the header.
        w_wr_nxt    = 1'b1;
        w_addr_nxt  = w_slot_base;
        w_be_nxt    = 4'hF;
        w_data_nxt  = {15'd0, r_err, 5'd0, r_count};
        w_state_nxt = c_hdr;
      end
      c_hdr:   w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase

    if (w_store) begin
      w_count_nxt = w_cur_count + 11'd1;
      w_word_nxt  = w_packed;
      w_state_nxt = st_eop ? c_flush : c_data;
      if (st_eop) begin
        w_err_nxt = st_error;
      end
      if (st_eop || w_lane == 2'd3) begin
        w_wr_nxt   = 1'b1;
        w_addr_nxt = w_slot_base + ADDR_W'(w_cur_count[10:2]) + ADDR_W'(1);
        w_be_nxt   = w_lane_be;
        w_data_nxt = w_packed;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_idle;
      r_ready   <= 1'b0;
      r_count   <= 11'd0;
      r_word    <= 32'd0;
      r_err     <= 1'b0;
      r_wr_slot <= 4'd0;
      r_pending <= 4'd0;
      r_drop    <= 16'd0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_be      <= 4'd0;
      r_data    <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= (w_state_nxt != c_flush) && (w_state_nxt != c_hdr);
      r_count   <= w_count_nxt;
      r_word    <= w_word_nxt;
      r_err     <= w_err_nxt;
      r_wr      <= w_wr_nxt;
      r_addr    <= w_addr_nxt;
      r_be      <= w_be_nxt;
      r_data    <= w_data_nxt;
      r_pending <= r_pending + {3'd0, w_commit} - {3'd0, w_release};
      if (w_commit) begin
        r_wr_slot <= (r_wr_slot == 4'(NUM_SLOTS - 1)) ? 4'd0 : r_wr_slot + 4'd1;
      end
      if (w_drop_inc && r_drop != 16'hFFFF) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign st_ready       = r_ready;
  assign ram_address    = r_addr;
  assign ram_byteenable = r_be;
  assign ram_chipselect = r_wr;
  assign ram_write      = r_wr;
  assign ram_writedata  = r_data;
  assign frames_pending = r_pending;
  assign wr_slot        = r_wr_slot;
  assign drop_count     = r_drop;
  assign irq            = (r_pending != 4'd0);

endmodule
`default_nettype wire

// File: doc/eth_rx_frame_writer.md
Name: eth_rx_frame_writer

Overview:
Receive-side stage that sits directly upstream of the dual-port on-chip RAM. It consumes the 8-bit Avalon-ST byte stream from the Ethernet MAC RX path, packs the bytes little-endian into 32-bit words and writes each frame into a ring of fixed-size slots through the RAM's second Avalon-MM slave port. When a frame completes it writes a header word and signals the Nios CPU, which frees slots with a release pulse.

Parameters:
BASE_WORD, 0, word address of slot 0 in the RAM
SLOT_WORDS, 384, words per slot: 1 header word plus 383 data words (1532 bytes max)
NUM_SLOTS, 8, number of slots in the ring (2..15)
ADDR_W, 19, RAM word-address width; BASE_WORD + NUM_SLOTS*SLOT_WORDS must be <= 393216

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous active-low reset
st_data  in  8  stream byte
st_valid  in  1  byte valid
st_sop  in  1  first byte of a frame
st_eop  in  1  last byte of a frame
st_error  in  1  MAC error flag, sampled with eop
st_ready  out  1  sink ready; a beat transfers when st_valid & st_ready
ram_address  out  ADDR_W  RAM word address
ram_byteenable  out  4  byte lanes; lane k = bits 8k+7:8k
ram_chipselect  out  1  equals ram_write
ram_write  out  1  one-cycle write strobe; the RAM has no waitrequest
ram_writedata  out  32  packed data or header
slot_release  in  1  one-cycle pulse from the CPU freeing the oldest pending slot
frames_pending  out  4  committed frames not yet released
wr_slot  out  4  slot currently being filled
drop_count  out  16  dropped-frame counter, saturates at 16'hFFFF
irq  out  1  level interrupt: frames_pending != 0

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, byte count 0. st_ready rises on the first clk after reset_n is released. Reset mid-frame discards the frame; no header is written.
- All RAM-port outputs are registered. A write issued for a beat accepted in cycle N appears on the port in cycle N+1.
- slot_base = BASE_WORD + wr_slot*SLOT_WORDS. The data word for index i goes to slot_base+1+i. The header goes to slot_base.
- States: IDLE, DATA, FLUSH, HDR, DROP.
- IDLE, st_ready=1:
  - Beats without sop are consumed and discarded.
  - sop with frames_pending==NUM_SLOTS: drop_count++. Go to DROP, or stay in IDLE if the same beat carries eop.
  - sop with a free slot: byte goes to lane 0, count=1. Go to DATA, or to FLUSH if eop is on the same beat.
- DATA, st_ready=1:
  - Each accepted byte goes to lane (count mod 4).
  - On the 4th lane, write the word with byteenable 4'hF.
  - eop: go to FLUSH.
  - sop without a prior eop: abort the current frame, drop_count++, restart at the same slot with the new byte.
  - Count would exceed 1532: drop_count++, go to DROP, or to IDLE if that beat is eop. The slot is not committed.
- FLUSH, st_ready=0, 1 cycle:
  - If count mod 4 != 0, write the partial word with byteenable = lanes filled (1 byte -> 4'b0001, 2 -> 4'b0011, 3 -> 4'b0111). Unfilled lanes are written as 0.
  - If count mod 4 == 0, there is no write.
  - Go to HDR.
- HDR, st_ready=0, 1 cycle:
  - Write the header: [15:0] = byte count, [16] = st_error latched at eop, [31:17] = 0, byteenable 4'hF.
  - wr_slot advances, wrapping NUM_SLOTS-1 -> 0.
  - frames_pending++. Go to IDLE.
- DROP, st_ready=1: consume beats until eop, then go to IDLE. A sop seen in DROP is treated as a new frame in IDLE.
- Timing: eop accepted in cycle N -> final data word on the port in N+1 (if any) -> header in N+2 -> frames_pending and wr_slot update visible in N+3. st_ready is low in N+1 and N+2.
- slot_release:
  - Decrements frames_pending when it is > 0; ignored at 0.
  - A release and a commit in the same cycle leave frames_pending unchanged.
  - A release while full frees the slot for the next sop.
- st_ready is never low for more than 2 consecutive cycles after reset.

Test Plan:
- 64-byte frame 0x00..0x3F, slot 0, BASE_WORD 0 -> 16 writes, addr 1..16, word 1 = 32'h03020100, header at addr 0 = 32'h00000040, frames_pending=1, irq=1.
- 5-byte frame with st_error=1 at eop -> writes to addr 1 (be F) and addr 2 (be 4'b0001, data 32'h00000004), header 32'h00010005, st_ready low exactly 2 cycles.
- 9 back-to-back 60-byte frames, no release -> slots 0..7 filled, wr_slot wraps to 0, 9th frame dropped, drop_count=1, no RAM writes during the 9th.
- slot_release in the same cycle as an HDR commit with frames_pending=3 -> frames_pending stays 3. A release at 0 -> stays 0.
- 1600-byte frame -> drop_count++, no header write, wr_slot unchanged. The next 64-byte frame lands in the same slot.
- reset_n asserted after 10 bytes of a frame -> all outputs 0 immediately. After release, a new frame writes to slot 0 with a correct header.
